// File: rtl/medidor_faixa_pkg.sv
// State codes and default limits shared by the range-meter control unit and its top level.
package medidor_faixa_pkg;

   typedef enum logic [3:0] {
      INICIAL          = 4'd0,
      PREPARACAO       = 4'd1,
      MEDIR            = 4'd2,
      AGUARDA_MEDIDA   = 4'd3,
      TRANSMITE        = 4'd4,
      ESPERA_TX        = 4'd5,
      PROXIMO_CHAR     = 4'd6,
      FIM_TX           = 4'd7,
      ESPERA_INTERVALO = 4'd8,
      ACERTOU          = 4'd9,
      ERRO             = 4'd10
   } estado_t;

   localparam int MAX_TIMEOUTS_DEFAULT = 3;

endpackage

// File: rtl/medidor_faixa_uc_if.sv
// Control/status bundle between the range-meter control unit (master) and its datapath (slave).
interface medidor_faixa_uc_if;
   logic       ligar;
   logic       pronto_medida;
   logic       pronto_tx;
   logic       is_ultimo_char;
   logic       fim_time;
   logic       acertou;

   logic       zera;
   logic       zera_char;
   logic       zera_time;
   logic       conta_time;
   logic       conta_prox_char;
   logic       mensurar;
   logic       partida_tx;
   logic       pronto;
   logic       erro;
   logic [3:0] db_estado;
   logic [1:0] db_timeouts;

   modport master (
      input  ligar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, acertou,
      output zera, zera_char, zera_time, conta_time, conta_prox_char, mensurar,
             partida_tx, pronto, erro, db_estado, db_timeouts
   );

   modport slave (
      output ligar, pronto_medida, pronto_tx, is_ultimo_char, fim_time, acertou,
      input  zera, zera_char, zera_time, conta_time, conta_prox_char, mensurar,
             partida_tx, pronto, erro, db_estado, db_timeouts
   );
endinterface

// File: rtl/medidor_faixa_uc.sv
// Moore control unit: measure, send the 4-char frame, wait the interval, stop on 3 s in range.
//
// state            | meaning
// INICIAL          | idle, waits for ligar
// PREPARACAO       | clears datapath, char selector, interval counter
// MEDIR            | starts a sensor measurement
// AGUARDA_MEDIDA   | waits for the echo or the 100 ms timeout
// TRANSMITE        | starts one serial character
// ESPERA_TX        | waits for the character to finish
// PROXIMO_CHAR     | advances the character selector
// FIM_TX           | frame sent, restarts the interval counter
// ESPERA_INTERVALO | waits for the interval, success or stop
// ACERTOU          | target held in range, waits for ligar low
// ERRO             | too many timeouts, waits for ligar low
module medidor_faixa_uc
   import medidor_faixa_pkg::*;
#(
   parameter int MAX_TIMEOUTS = MAX_TIMEOUTS_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   medidor_faixa_uc_if.master uc
);

   localparam logic [1:0] MAX_T = 2'(MAX_TIMEOUTS);

   estado_t    estado_q, estado_d;
   logic [1:0] timeouts_q, timeouts_d;
   logic [1:0] timeouts_inc;

   always_ff @(posedge clock) begin
      if (reset) begin
         estado_q   <= INICIAL;
         timeouts_q <= 2'd0;
      end else begin
         estado_q   <= estado_d;
         timeouts_q <= timeouts_d;
      end
   end

   // saturating so the count never wraps past the limit
   assign timeouts_inc = (timeouts_q >= MAX_T) ? MAX_T : timeouts_q + 2'd1;

   always_comb begin
      estado_d   = estado_q;
      timeouts_d = timeouts_q;
      case (estado_q)
         INICIAL:          if (uc.ligar) estado_d = PREPARACAO;
         PREPARACAO: begin
            timeouts_d = 2'd0;
            estado_d   = MEDIR;
         end
         MEDIR:            estado_d = AGUARDA_MEDIDA;
         AGUARDA_MEDIDA: begin
            if (uc.pronto_medida) begin
               timeouts_d = 2'd0;
               estado_d   = TRANSMITE;
            end else if (uc.fim_time) begin
               timeouts_d = timeouts_inc;
               estado_d   = (timeouts_inc == MAX_T) ? ERRO : MEDIR;
            end
         end
         TRANSMITE:        estado_d = ESPERA_TX;
         ESPERA_TX: begin
            if (uc.pronto_tx) estado_d = uc.is_ultimo_char ? FIM_TX : PROXIMO_CHAR;
         end
         PROXIMO_CHAR:     estado_d = TRANSMITE;
         FIM_TX:           estado_d = ESPERA_INTERVALO;
         ESPERA_INTERVALO: begin
            if (uc.acertou)       estado_d = ACERTOU;
            else if (!uc.ligar)   estado_d = INICIAL;
            else if (uc.fim_time) estado_d = MEDIR;
         end
         ACERTOU:          if (!uc.ligar) estado_d = INICIAL;
         ERRO:             if (!uc.ligar) estado_d = INICIAL;
         default:          estado_d = INICIAL;
      endcase
   end

   always_comb begin
      uc.zera            = 1'b0;
      uc.zera_char       = 1'b0;
      uc.zera_time       = 1'b0;
      uc.conta_time      = 1'b0;
      uc.conta_prox_char = 1'b0;
      uc.mensurar        = 1'b0;
      uc.partida_tx      = 1'b0;
      uc.pronto          = 1'b0;
      uc.erro            = 1'b0;
      case (estado_q)
         PREPARACAO: begin
            uc.zera      = 1'b1;
            uc.zera_char = 1'b1;
            uc.zera_time = 1'b1;
         end
         MEDIR: begin
            uc.mensurar  = 1'b1;
            uc.zera_time = 1'b1;
         end
         AGUARDA_MEDIDA:   uc.conta_time      = 1'b1;
         TRANSMITE:        uc.partida_tx      = 1'b1;
         PROXIMO_CHAR:     uc.conta_prox_char = 1'b1;
         FIM_TX: begin
            uc.zera_char = 1'b1;
            uc.zera_time = 1'b1;
         end
         ESPERA_INTERVALO: uc.conta_time      = 1'b1;
         ACERTOU:          uc.pronto          = 1'b1;
         ERRO:             uc.erro            = 1'b1;
         default: ;
      endcase
   end

   assign uc.db_estado   = estado_q;
   assign uc.db_timeouts = timeouts_q;

endmodule

// File: tb/tb_medidor_faixa_uc.sv
// Scoreboard bench for medidor_faixa_uc: stimulus queues expected state/outputs, a monitor checks them.
module tb_medidor_faixa_uc;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   n_tx = 0;
   int   n_pc = 0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   medidor_faixa_uc_if bus ();

   medidor_faixa_uc #(.MAX_TIMEOUTS(3)) dut (
      .clock (clk),
      .reset (rst),
      .uc    (bus.master)
   );

   // {zera, zera_char, zera_time, conta_time, conta_prox_char, mensurar, partida_tx, pronto, erro}
   localparam logic [8:0] O_NONE = 9'b000_000_000;
   localparam logic [8:0] O_PREP = 9'b111_000_000;
   localparam logic [8:0] O_MED  = 9'b001_001_000;
   localparam logic [8:0] O_CONT = 9'b000_100_000;
   localparam logic [8:0] O_TX   = 9'b000_000_100;
   localparam logic [8:0] O_PC   = 9'b000_010_000;
   localparam logic [8:0] O_FIM  = 9'b011_000_000;
   localparam logic [8:0] O_OK   = 9'b000_000_010;
   localparam logic [8:0] O_ERR  = 9'b000_000_001;

   typedef struct {
      string      name;
      int         cyc;
      logic [3:0] st;
      logic [8:0] outs;
      int         to;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string name, input logic [3:0] st, input logic [8:0] outs,
                             input int to);
      exp_t e;
      e.name = name;
      e.cyc  = cyc;
      e.st   = st;
      e.outs = outs;
      e.to   = to;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      logic [8:0] outs;
      exp_t       e;
      outs = {bus.zera, bus.zera_char, bus.zera_time, bus.conta_time, bus.conta_prox_char,
              bus.mensurar, bus.partida_tx, bus.pronto, bus.erro};
      if (bus.partida_tx)      n_tx++;
      if (bus.conta_prox_char) n_pc++;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         total++;
         if (e.cyc < cyc) begin
            bad++;
            $display("FAIL %s: check missed at cycle %0d (now %0d)", e.name, e.cyc, cyc);
         end else if (bus.db_estado !== e.st || outs !== e.outs ||
                      (e.to >= 0 && int'(bus.db_timeouts) != e.to)) begin
            bad++;
            $display("FAIL %s: got estado=%0d outs=%b to=%0d expected estado=%0d outs=%b to=%0d",
                     e.name, bus.db_estado, outs, bus.db_timeouts, e.st, e.outs, e.to);
         end
      end
   end

   // Enters with the FSM in TRANSMITE for the first character; leaves it in ESPERA_INTERVALO.
   task automatic run_frame(input string tag, input bit set_ac);
      n_tx = 0;
      n_pc = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         expect_now({tag, "_espera_tx"}, 4'd5, O_NONE, 0);
         if (k == 0 && set_ac) bus.acertou = 1'b1;
         repeat (9) tick();
         bus.pronto_tx      = 1'b1;
         bus.is_ultimo_char = (k == 3);
         tick();
         bus.pronto_tx      = 1'b0;
         bus.is_ultimo_char = 1'b0;
         if (k < 3) begin
            expect_now({tag, "_prox_char"}, 4'd6, O_PC, 0);
            tick();
            expect_now({tag, "_transmite"}, 4'd4, O_TX, 0);
         end else begin
            expect_now({tag, "_fim_tx"}, 4'd7, O_FIM, 0);
         end
      end
      tick();
      expect_now({tag, "_intervalo"}, 4'd8, O_CONT, 0);
      chk({tag, "_n_partida_tx"}, n_tx, 4);
      chk({tag, "_n_prox_char"}, n_pc, 3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst                = 1'b1;
      bus.ligar          = 1'b1;
      bus.pronto_medida  = 1'b0;
      bus.pronto_tx      = 1'b0;
      bus.is_ultimo_char = 1'b0;
      bus.fim_time       = 1'b0;
      bus.acertou        = 1'b0;

      // reset held two cycles with ligar high
      tick();
      tick();
      expect_now("reset", 4'd0, O_NONE, 0);
      rst = 1'b0;
      tick();
      expect_now("preparacao", 4'd1, O_PREP, 0);
      tick();
      expect_now("medir_after_reset", 4'd2, O_MED, 0);
      tick();
      expect_now("aguarda", 4'd3, O_CONT, 0);

      // normal frame
      bus.pronto_medida = 1'b1;
      tick();
      bus.pronto_medida = 1'b0;
      expect_now("first_partida", 4'd4, O_TX, 0);
      run_frame("frame1", 1'b0);

      // interval end restarts measurement
      bus.fim_time = 1'b1;
      tick();
      bus.fim_time = 1'b0;
      expect_now("interval_medir", 4'd2, O_MED, 0);
      tick();
      expect_now("aguarda2", 4'd3, O_CONT, 0);

      // three consecutive timeouts
      bus.fim_time = 1'b1;
      tick();
      bus.fim_time = 1'b0;
      expect_now("timeout1_medir", 4'd2, O_MED, 1);
      tick();
      expect_now("timeout1_aguarda", 4'd3, O_CONT, 1);
      bus.fim_time = 1'b1;
      tick();
      bus.fim_time = 1'b0;
      expect_now("timeout2_medir", 4'd2, O_MED, 2);
      tick();
      expect_now("timeout2_aguarda", 4'd3, O_CONT, 2);
      bus.fim_time = 1'b1;
      tick();
      bus.fim_time = 1'b0;
      expect_now("timeout3_erro", 4'd10, O_ERR, 3);
      tick();
      expect_now("erro_holds", 4'd10, O_ERR, 3);
      bus.ligar = 1'b0;
      tick();
      expect_now("erro_to_inicial", 4'd0, O_NONE, 3);
      tick();
      expect_now("inicial_idle", 4'd0, O_NONE, 3);

      // restart clears the timeout count, then a successful run
      bus.ligar = 1'b1;
      tick();
      expect_now("prep2", 4'd1, O_PREP, -1);
      tick();
      expect_now("medir_cleared", 4'd2, O_MED, 0);
      tick();
      expect_now("aguarda3", 4'd3, O_CONT, 0);
      bus.pronto_medida = 1'b1;
      tick();
      bus.pronto_medida = 1'b0;
      expect_now("ok_partida", 4'd4, O_TX, 0);
      run_frame("frame_ok", 1'b1);
      tick();
      expect_now("acertou", 4'd9, O_OK, 0);
      tick();
      expect_now("acertou_holds", 4'd9, O_OK, 0);
      bus.ligar = 1'b0;
      tick();
      bus.acertou = 1'b0;
      expect_now("acertou_to_inicial", 4'd0, O_NONE, 0);

      // reset in the middle of a transmission
      bus.ligar = 1'b1;
      tick();
      tick();
      tick();
      bus.pronto_medida = 1'b1;
      tick();
      bus.pronto_medida = 1'b0;
      expect_now("mid_partida", 4'd4, O_TX, 0);
      tick();
      expect_now("mid_espera_tx", 4'd5, O_NONE, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_now("mid_reset", 4'd0, O_NONE, 0);

      // one timeout, then echo and timeout together: echo wins and clears the count
      tick();
      tick();
      expect_now("tb_medir", 4'd2, O_MED, 0);
      tick();
      bus.fim_time = 1'b1;
      tick();
      bus.fim_time = 1'b0;
      expect_now("tb_timeout", 4'd2, O_MED, 1);
      tick();
      bus.pronto_medida = 1'b1;
      bus.fim_time      = 1'b1;
      tick();
      bus.pronto_medida = 1'b0;
      bus.fim_time      = 1'b0;
      expect_now("tie_break", 4'd4, O_TX, 0);

      tick();
      tick();
      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
